// File: rtl/prio_scan_pkg.sv
// Shared types and helpers for the sequential priority scan encoder.
package prio_scan_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    SCAN = 1'b1
  } state_e;

  // Widest vector the helper below accepts; callers zero-extend into it.
  localparam int MAX_VEC_W = 1024;

  function automatic int idx_w(input int width);
    return (width <= 2) ? 1 : $clog2(width);
  endfunction

  function automatic logic onehot_or_zero(input logic [MAX_VEC_W-1:0] vec);
    return ((vec & (vec - MAX_VEC_W'(1))) == '0);
  endfunction

endpackage

// File: rtl/prio_find_first.sv
// Combinational priority pick: index of the highest (MSB_FIRST=1) or lowest set bit.
module prio_find_first
  import prio_scan_pkg::*;
#(
  parameter int WIDTH     = 8,
  parameter bit MSB_FIRST = 1'b1,
  parameter int IDX_W     = idx_w(WIDTH)
) (
  input  logic [WIDTH-1:0] vec,
  output logic [IDX_W-1:0] idx,
  output logic             found
);

  // Later loop iterations overwrite earlier ones, so scan toward the winning end.
  always_comb begin
    idx   = '0;
    found = 1'b0;
    if (MSB_FIRST) begin
      for (int i = 0; i < WIDTH; i++) begin
        if (vec[i]) begin
          idx   = IDX_W'(i);
          found = 1'b1;
        end
      end
    end else begin
      for (int i = WIDTH - 1; i >= 0; i--) begin
        if (vec[i]) begin
          idx   = IDX_W'(i);
          found = 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/prio_scan_encoder.sv
// Captures a request vector and emits the index of each set bit, one beat per cycle.
// Optional flush input enabled by defining PRIO_SCAN_FLUSH_EN.
module prio_scan_encoder
  import prio_scan_pkg::*;
#(
  parameter int WIDTH     = 8,
  parameter int IDX_W     = $clog2(WIDTH),
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
`ifdef PRIO_SCAN_FLUSH_EN
  input  logic             flush,
`endif
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_vec,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [IDX_W-1:0] out_idx,
  output logic             out_last,
  output logic             zero_seen
);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] pending_q, pending_d;
  logic             zero_seen_q, zero_seen_d;
  logic [IDX_W-1:0] pick_idx;
  logic             pick_found;

  prio_find_first #(
    .WIDTH     (WIDTH),
    .MSB_FIRST (MSB_FIRST),
    .IDX_W     (IDX_W)
  ) u_find (
    .vec   (pending_q),
    .idx   (pick_idx),
    .found (pick_found)
  );

  assign in_ready  = (state_q == IDLE) && !rst;
  assign out_valid = (state_q == SCAN);
  assign out_idx   = pick_idx;
  // pending is zero outside SCAN, which would otherwise read as "last".
  assign out_last  = (state_q == SCAN) && onehot_or_zero(MAX_VEC_W'(pending_q));
  assign zero_seen = zero_seen_q;

  always_comb begin
    state_d     = state_q;
    pending_d   = pending_q;
    zero_seen_d = 1'b0;
    if (state_q == IDLE) begin
      if (in_valid) begin
        if (|in_vec) begin
          pending_d = in_vec;
          state_d   = SCAN;
        end else begin
          zero_seen_d = 1'b1;
        end
      end
    end else begin
      if (out_ready && pick_found) begin
        pending_d = pending_q & ~(WIDTH'(1) << pick_idx);
        if (out_last) state_d = IDLE;
      end
`ifdef PRIO_SCAN_FLUSH_EN
      if (flush) begin
        pending_d = '0;
        state_d   = IDLE;
      end
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      pending_q   <= '0;
      zero_seen_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      pending_q   <= pending_d;
      zero_seen_q <= zero_seen_d;
    end
  end

endmodule

// File: tb/tb_prio_scan_encoder.sv
// Bench for prio_scan_encoder: three configurations run in lockstep against a queue-based model.
module tb_prio_scan_encoder;

  logic       clk = 1'b0;
  logic       rst, in_valid, out_ready, flush;
  logic [7:0] in_vec;
  logic       ov[3], ol[3], ir[3], zs[3];
  logic [2:0] oi[3];

  always #5 clk = ~clk;

  prio_scan_encoder #(.WIDTH(8), .MSB_FIRST(1'b1)) u_a (
    .clk(clk), .rst(rst),
`ifdef PRIO_SCAN_FLUSH_EN
    .flush(flush),
`endif
    .in_valid(in_valid), .in_ready(ir[0]), .in_vec(in_vec),
    .out_valid(ov[0]), .out_ready(out_ready), .out_idx(oi[0]),
    .out_last(ol[0]), .zero_seen(zs[0]));

  prio_scan_encoder #(.WIDTH(8), .MSB_FIRST(1'b0)) u_b (
    .clk(clk), .rst(rst),
`ifdef PRIO_SCAN_FLUSH_EN
    .flush(flush),
`endif
    .in_valid(in_valid), .in_ready(ir[1]), .in_vec(in_vec),
    .out_valid(ov[1]), .out_ready(out_ready), .out_idx(oi[1]),
    .out_last(ol[1]), .zero_seen(zs[1]));

  prio_scan_encoder #(.WIDTH(5), .MSB_FIRST(1'b1)) u_c (
    .clk(clk), .rst(rst),
`ifdef PRIO_SCAN_FLUSH_EN
    .flush(flush),
`endif
    .in_valid(in_valid), .in_ready(ir[2]), .in_vec(in_vec[4:0]),
    .out_valid(ov[2]), .out_ready(out_ready), .out_idx(oi[2]),
    .out_last(ol[2]), .zero_seen(zs[2]));

  int n_cmp  = 0;
  int n_fail = 0;
  bit checking = 1'b0;

  // Model: per instance, the list of indices still to be emitted, in emission order.
  int mq[3][$];
  bit mz[3];

  int obs_cnt[3], obs_first[3], obs_last[3], obs_z[3];

  typedef struct {
    logic [7:0] vec;
    int stall;
    int cnt8;
    int a_first, a_last, b_first, b_last;
    int cnt5;
    int c_first, c_last;
  } vec_t;

  vec_t tbl[7];

  function automatic void chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, wanted %0d", name, act, exp);
    end
  endfunction

  task automatic model_update();
    for (int i = 0; i < 3; i++) begin
      int w;
      bit msb;
      bit znext;
      logic [7:0] v;
      int b;
      w = (i == 2) ? 5 : 8;
      msb = (i != 1);
      v = (i == 2) ? {3'b000, in_vec[4:0]} : in_vec;
      znext = 1'b0;
      if (rst) begin
        mq[i].delete();
      end else if (mq[i].size() == 0) begin
        if (in_valid) begin
          if (v == 8'h00) znext = 1'b1;
          else begin
            for (int k = 0; k < w; k++) begin
              b = msb ? (w - 1 - k) : k;
              if (v[b]) mq[i].push_back(b);
            end
          end
        end
      end else begin
        if (out_ready) void'(mq[i].pop_front());
        if (flush) mq[i].delete();
      end
      mz[i] = znext;
    end
  endtask

  task automatic check_outputs();
    for (int i = 0; i < 3; i++) begin
      bit ev;
      int eidx;
      ev = (mq[i].size() != 0);
      eidx = ev ? mq[i][0] : 0;
      chk($sformatf("out_valid[%0d]", i), int'(ov[i]), int'(ev));
      chk($sformatf("out_idx[%0d]", i), int'(oi[i]), eidx);
      chk($sformatf("out_last[%0d]", i), int'(ol[i]), int'(mq[i].size() == 1));
      chk($sformatf("in_ready[%0d]", i), int'(ir[i]), int'(!ev && !rst));
      chk($sformatf("zero_seen[%0d]", i), int'(zs[i]), int'(mz[i]));
      if (zs[i]) obs_z[i]++;
    end
  endtask

  task automatic observe();
    for (int i = 0; i < 3; i++) begin
      if (ov[i] && out_ready) begin
        if (obs_cnt[i] == 0) obs_first[i] = int'(oi[i]);
        if (ol[i]) obs_last[i] = int'(oi[i]);
        obs_cnt[i]++;
      end
    end
  endtask

  task automatic step();
    observe();
    @(posedge clk);
    model_update();
    @(negedge clk);
    if (checking) check_outputs();
  endtask

  task automatic clear_obs();
    for (int i = 0; i < 3; i++) begin
      obs_cnt[i] = 0;
      obs_first[i] = -1;
      obs_last[i] = -1;
      obs_z[i] = 0;
    end
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while (!(ir[0] && ir[1] && ir[2]) && n < 40) begin
      step();
      n++;
    end
    chk("idle_timeout", int'(n < 40), 1);
  endtask

  task automatic run_entry(input vec_t e, input int t);
    wait_idle();
    clear_obs();
    in_vec = e.vec;
    in_valid = 1'b1;
    out_ready = 1'b1;
    step();
    in_valid = 1'b0;
    out_ready = 1'b0;
    repeat (e.stall) step();
    out_ready = 1'b1;
    wait_idle();
    chk($sformatf("t%0d a_count", t), obs_cnt[0], e.cnt8);
    chk($sformatf("t%0d a_first", t), obs_first[0], e.a_first);
    chk($sformatf("t%0d a_last", t), obs_last[0], e.a_last);
    chk($sformatf("t%0d b_count", t), obs_cnt[1], e.cnt8);
    chk($sformatf("t%0d b_first", t), obs_first[1], e.b_first);
    chk($sformatf("t%0d b_last", t), obs_last[1], e.b_last);
    chk($sformatf("t%0d c_count", t), obs_cnt[2], e.cnt5);
    chk($sformatf("t%0d c_first", t), obs_first[2], e.c_first);
    chk($sformatf("t%0d c_last", t), obs_last[2], e.c_last);
    chk($sformatf("t%0d a_zero_pulses", t), obs_z[0], (e.cnt8 == 0) ? 1 : 0);
    chk($sformatf("t%0d b_zero_pulses", t), obs_z[1], (e.cnt8 == 0) ? 1 : 0);
    chk($sformatf("t%0d c_zero_pulses", t), obs_z[2], (e.cnt5 == 0) ? 1 : 0);
  endtask

  task automatic abort_mid_scan(input bit use_flush);
    wait_idle();
    clear_obs();
    in_vec = 8'hFF;
    in_valid = 1'b1;
    out_ready = 1'b1;
    step();
    in_valid = 1'b0;
    step();
    if (use_flush) flush = 1'b1;
    else begin
      rst = 1'b1;
      out_ready = 1'b0;
    end
    step();
    rst = 1'b0;
    flush = 1'b0;
    out_ready = 1'b1;
    #1;
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("abort%0d out_valid[%0d]", use_flush, i), int'(ov[i]), 0);
      chk($sformatf("abort%0d in_ready[%0d]", use_flush, i), int'(ir[i]), 1);
    end
    repeat (3) step();
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("abort%0d beats[%0d]", use_flush, i), obs_cnt[i], use_flush ? 2 : 1);
      chk($sformatf("abort%0d last_seen[%0d]", use_flush, i), obs_last[i], -1);
    end
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    tbl[0] = '{8'hA4, 0, 3, 7, 2, 2, 7, 1, 2, 2};
    tbl[1] = '{8'hA4, 3, 3, 7, 2, 2, 7, 1, 2, 2};
    tbl[2] = '{8'h00, 0, 0, -1, -1, -1, -1, 0, -1, -1};
    tbl[3] = '{8'h11, 0, 2, 4, 0, 0, 4, 2, 4, 0};
    tbl[4] = '{8'h01, 1, 1, 0, 0, 0, 0, 1, 0, 0};
    tbl[5] = '{8'h80, 0, 1, 7, 7, 7, 7, 0, -1, -1};
    tbl[6] = '{8'hFF, 2, 8, 7, 0, 0, 7, 5, 4, 0};

    rst = 1'b1;
    in_valid = 1'b0;
    out_ready = 1'b0;
    in_vec = 8'h00;
    flush = 1'b0;
    clear_obs();
    step();
    checking = 1'b1;
    step();
    rst = 1'b0;
    #1;
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("reset in_ready[%0d]", i), int'(ir[i]), 1);
      chk($sformatf("reset out_valid[%0d]", i), int'(ov[i]), 0);
      chk($sformatf("reset out_idx[%0d]", i), int'(oi[i]), 0);
      chk($sformatf("reset out_last[%0d]", i), int'(ol[i]), 0);
      chk($sformatf("reset zero_seen[%0d]", i), int'(zs[i]), 0);
    end

    for (int t = 0; t < 7; t++) run_entry(tbl[t], t);

    abort_mid_scan(1'b0);
`ifdef PRIO_SCAN_FLUSH_EN
    abort_mid_scan(1'b1);
`endif

    for (int c = 0; c < 3000; c++) begin
      rst = ($urandom_range(0, 63) == 0);
      in_valid = $urandom_range(0, 1) == 1;
      in_vec = ($urandom_range(0, 7) == 0) ? 8'h00 : 8'($urandom);
      out_ready = ($urandom_range(0, 3) != 0);
`ifdef PRIO_SCAN_FLUSH_EN
      flush = ($urandom_range(0, 31) == 0);
`endif
      step();
    end
    rst = 1'b0;
    in_valid = 1'b0;
    flush = 1'b0;
    out_ready = 1'b1;
    wait_idle();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
